// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width derivation and gray/binary conversion.
package fifo_pkg;

    localparam int ADDR_W_DEF = 4;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_ptr_full_gray2bin.sv
// Combinational gray-to-binary converter; each bit is the XOR of itself and all higher bits.
module gray2bin #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// Async FIFO write side: binary/gray write pointer, full/almost-full,
// fill level and sticky overflow, all registered in the write clock domain.
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AFULL_TH = 2**ADDR_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_gray_sync,
    output logic              mem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W:0]   wr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int PTR_W = ptr_w(ADDR_W);

    logic             accept;
    logic [PTR_W-1:0] wr_bin;
    logic [PTR_W-1:0] bin_next;
    logic [PTR_W-1:0] gray_next;
    logic [PTR_W-1:0] rd_bin;
    logic [PTR_W-1:0] level_next;
    logic [PTR_W-1:0] full_gray;

    gray2bin #(.N(PTR_W)) u_rd_g2b (
        .gray (rd_gray_sync),
        .bin  (rd_bin)
    );

    assign accept     = wr_en & ~full & ~rst;
    assign mem_we     = accept;
    assign wr_addr    = wr_bin[ADDR_W-1:0];
    assign bin_next   = wr_bin + {{ADDR_W{1'b0}}, accept};
    assign gray_next  = PTR_W'(bin2gray(32'(bin_next)));
    assign level_next = bin_next - rd_bin;

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_gray = {~rd_gray_sync[ADDR_W:ADDR_W-1],
                        rd_gray_sync[ADDR_W-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bin      <= '0;
            wr_gray     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_bin      <= bin_next;
            wr_gray     <= gray_next;
            full        <= (gray_next == full_gray);
            almost_full <= (level_next >= PTR_W'(AFULL_TH));
            wr_level    <= level_next;
            overflow    <= overflow | (wr_en & full);
        end
    end

endmodule
